// File: rtl/fnd_result_ctrl.sv
// Captures an adder/subtractor result, converts it to sign + two BCD digits,
// and scans it onto a 4-digit common-anode 7-segment display.
module fnd_result_ctrl #(
  parameter int CLK_DIV = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [3:0] i_sum,
  input  logic       i_carry,
  input  logic       i_sub,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_data,
  output logic       o_neg
);

  localparam int TW = $clog2(CLK_DIV);

  logic         r_cap_sub;
  logic         r_cap_carry;
  logic [3:0]   r_cap_sum;
  logic [1:0]   r_tens;
  logic [3:0]   r_ones;
  logic         r_neg;
  logic [TW-1:0] r_tick;
  logic [1:0]   r_idx;

  logic [4:0]   w_mag;
  logic         w_neg;
  logic [1:0]   w_tens;
  logic [3:0]   w_ones;
  logic [3:0]   w_com;
  logic [7:0]   w_data;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cap_sub   <= 1'b0;
      r_cap_carry <= 1'b0;
      r_cap_sum   <= 4'd0;
    end else if (i_valid) begin
      r_cap_sub   <= i_sub;
      r_cap_carry <= i_carry;
      r_cap_sum   <= i_sum;
    end
  end

  // A borrow (carry=0) in subtract mode means the true result is sum-16.
  always_comb begin
    w_neg = 1'b0;
    w_mag = {r_cap_carry, r_cap_sum};
    if (r_cap_sub) begin
      if (r_cap_carry) begin
        w_mag = {1'b0, r_cap_sum};
      end else begin
        w_mag = 5'd16 - {1'b0, r_cap_sum};
        w_neg = 1'b1;
      end
    end
  end

  always_comb begin
    w_tens = 2'd0;
    w_ones = w_mag[3:0];
    if (w_mag >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = 4'(w_mag - 5'd30);
    end else if (w_mag >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = 4'(w_mag - 5'd20);
    end else if (w_mag >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = 4'(w_mag - 5'd10);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tens <= 2'd0;
      r_ones <= 4'd0;
      r_neg  <= 1'b0;
    end else begin
      r_tens <= w_tens;
      r_ones <= w_ones;
      r_neg  <= w_neg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= '0;
      r_idx  <= 2'd0;
    end else if (r_tick == TW'(CLK_DIV - 1)) begin
      r_tick <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  always_comb begin
    w_com  = 4'b1111;
    w_data = 8'hFF;
    case (r_idx)
      2'd0: begin
        w_com  = 4'b1110;
        w_data = seg7(r_ones);
      end
      2'd1: begin
        w_com  = 4'b1101;
        w_data = (r_tens == 2'd0) ? 8'hFF : seg7({2'b00, r_tens});
      end
      2'd2: begin
        w_com  = 4'b1011;
        w_data = r_neg ? 8'hBF : 8'hFF;
      end
      default: begin
        w_com  = 4'b0111;
        w_data = r_cap_sub ? 8'h92 : 8'h88;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fnd_com  <= 4'b1111;
      o_fnd_data <= 8'hFF;
    end else begin
      o_fnd_com  <= w_com;
      o_fnd_data <= w_data;
    end
  end

  assign o_neg = r_neg;

endmodule

// File: tb/tb_fnd_result_ctrl.sv
// Bench for fnd_result_ctrl: directed display cases plus random captures
// compared against a signed-integer model of the displayed result.
module tb_fnd_result_ctrl;

  localparam int CLK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [3:0] i_sum;
  logic       i_carry;
  logic       i_sub;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_data;
  logic       o_neg;

  int checks;
  int errors;
  int edge_cnt;
  int m_value;
  bit m_sub;
  logic [7:0] seg_tab [10];
  logic [7:0] exp_seg [4];

  fnd_result_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .i_sum     (i_sum),
    .i_carry   (i_carry),
    .i_sub     (i_sub),
    .o_fnd_com (o_fnd_com),
    .o_fnd_data(o_fnd_data),
    .o_neg     (o_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the active slot follows from this count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic int model_value(input bit s, input bit c, input int sm);
    if (!s)     return c * 16 + sm;
    else if (c) return sm;
    else        return sm - 16;
  endfunction

  function automatic logic [7:0] model_seg(input int idx, input int value, input bit s);
    int mag;
    mag = (value < 0) ? -value : value;
    case (idx)
      0:       return seg_tab[mag % 10];
      1:       return (mag / 10 == 0) ? 8'hFF : seg_tab[mag / 10];
      2:       return (value < 0) ? 8'hBF : 8'hFF;
      default: return s ? 8'h92 : 8'h88;
    endcase
  endfunction

  task automatic strobe(input bit s, input bit c, input logic [3:0] sm);
    @(negedge clk);
    i_valid = 1'b1;
    i_sub   = s;
    i_carry = c;
    i_sum   = sm;
    @(negedge clk);
    i_valid = 1'b0;
    m_value = model_value(s, c, int'(sm));
    m_sub   = s;
    $display("txn sub=%0d carry=%0d sum=%0d -> value %0d", s, c, sm, m_value);
  endtask

  task automatic test_reset;
    logic [3:0] exp_com;
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_fnd_com !== 4'b1111 || o_fnd_data !== 8'hFF || o_neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: com=%b data=%h neg=%b, want 1111 FF 0", o_fnd_com, o_fnd_data, o_neg);
    end
    m_value = 0;
    m_sub   = 1'b0;
    rst_n   = 1'b1;
    $display("txn reset release");
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'h88};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k] || o_neg !== 1'b0) begin
        errors++;
        $display("FAIL reset_scan: com=%b data=%h neg=%b, want %b %h 0", o_fnd_com, o_fnd_data, o_neg, exp_com, exp_seg[k]);
      end
    end
  endtask

  task automatic test_add;
    logic [3:0] exp_com;
    int k;
    strobe(1'b0, 1'b1, 4'hB);
    @(negedge clk);
    checks++;
    if (o_neg !== 1'b0) begin
      errors++;
      $display("FAIL add27_neg: neg=%b, want 0", o_neg);
    end
    exp_seg = '{8'hF8, 8'hA4, 8'hFF, 8'h88};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k]) begin
        errors++;
        $display("FAIL add27_scan: com=%b data=%h, want %b %h", o_fnd_com, o_fnd_data, exp_com, exp_seg[k]);
      end
    end
  endtask

  task automatic test_sub;
    logic [3:0] exp_com;
    int k;
    strobe(1'b1, 1'b0, 4'hD);
    checks++;
    if (o_neg !== 1'b0) begin
      errors++;
      $display("FAIL sub3_neg_early: neg=%b, want 0 one clock after strobe", o_neg);
    end
    @(negedge clk);
    checks++;
    if (o_neg !== 1'b1) begin
      errors++;
      $display("FAIL sub3_neg: neg=%b, want 1", o_neg);
    end
    exp_seg = '{8'hB0, 8'hFF, 8'hBF, 8'h92};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k]) begin
        errors++;
        $display("FAIL sub3_scan: com=%b data=%h, want %b %h", o_fnd_com, o_fnd_data, exp_com, exp_seg[k]);
      end
    end
  endtask

  task automatic test_sub_boundary;
    logic [3:0] exp_com;
    int k;
    strobe(1'b1, 1'b0, 4'h0);
    @(negedge clk);
    checks++;
    if (o_neg !== 1'b1) begin
      errors++;
      $display("FAIL sub16_neg: neg=%b, want 1", o_neg);
    end
    exp_seg = '{8'h82, 8'hF9, 8'hBF, 8'h92};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k]) begin
        errors++;
        $display("FAIL sub16_scan: com=%b data=%h, want %b %h", o_fnd_com, o_fnd_data, exp_com, exp_seg[k]);
      end
    end
    strobe(1'b1, 1'b1, 4'h0);
    @(negedge clk);
    checks++;
    if (o_neg !== 1'b0) begin
      errors++;
      $display("FAIL sub0_neg: neg=%b, want 0", o_neg);
    end
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'h92};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k]) begin
        errors++;
        $display("FAIL sub0_scan: com=%b data=%h, want %b %h", o_fnd_com, o_fnd_data, exp_com, exp_seg[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_com;
    int k;
    @(negedge clk);
    i_valid = 1'b1;
    i_sub   = 1'b0;
    i_carry = 1'b0;
    i_sum   = 4'd5;
    $display("txn sub=0 carry=0 sum=5 (back-to-back first)");
    @(negedge clk);
    i_sum   = 4'd9;
    $display("txn sub=0 carry=0 sum=9 (back-to-back second)");
    @(negedge clk);
    i_valid = 1'b0;
    m_value = 9;
    m_sub   = 1'b0;
    @(negedge clk);
    checks++;
    if (o_neg !== 1'b0) begin
      errors++;
      $display("FAIL b2b_neg: neg=%b, want 0", o_neg);
    end
    exp_seg = '{8'h90, 8'hFF, 8'hFF, 8'h88};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k]) begin
        errors++;
        $display("FAIL b2b_scan: com=%b data=%h, want %b %h", o_fnd_com, o_fnd_data, exp_com, exp_seg[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp_com;
    int k;
    strobe(1'b1, 1'b0, 4'hD);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    $display("txn reset asserted mid-slot");
    #1;
    checks++;
    if (o_fnd_com !== 4'b1111 || o_fnd_data !== 8'hFF || o_neg !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: com=%b data=%h neg=%b, want 1111 FF 0", o_fnd_com, o_fnd_data, o_neg);
    end
    repeat (2) @(negedge clk);
    m_value = 0;
    m_sub   = 1'b0;
    rst_n   = 1'b1;
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'h88};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = ((edge_cnt - 1) / CLK_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_seg[k] || o_neg !== 1'b0) begin
        errors++;
        $display("FAIL midreset_scan: com=%b data=%h neg=%b, want %b %h 0", o_fnd_com, o_fnd_data, o_neg, exp_com, exp_seg[k]);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] exp_com;
    logic [7:0] exp_data;
    bit s;
    bit c;
    logic [3:0] sm;
    int k;
    for (int n = 0; n < 24; n++) begin
      s  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      sm = 4'($urandom_range(0, 15));
      strobe(s, c, sm);
      @(negedge clk);
      checks++;
      if (o_neg !== (m_value < 0)) begin
        errors++;
        $display("FAIL rand_neg: neg=%b, want %b (value %0d)", o_neg, (m_value < 0), m_value);
      end
      for (int t = 0; t < 16; t++) begin
        @(negedge clk);
        k = ((edge_cnt - 1) / CLK_DIV) % 4;
        exp_com = 4'b1111;
        exp_com[k] = 1'b0;
        exp_data = model_seg(k, m_value, m_sub);
        checks++;
        if (o_fnd_com !== exp_com || o_fnd_data !== exp_data) begin
          errors++;
          $display("FAIL rand_scan: value %0d com=%b data=%h, want %b %h", m_value, o_fnd_com, o_fnd_data, exp_com, exp_data);
        end
      end
    end
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sum   = 4'd0;
    i_carry = 1'b0;
    i_sub   = 1'b0;
    m_value = 0;
    m_sub   = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_sub_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
